ex_stage_mc: RTL

Parametrised execute stage for the pipelined RISC core. Sits between operand fetch/decode and the MEM stage. Adds a valid/ready handshake, flush, and an iterative multi-cycle multiplier that stalls the upstream pipe while it runs. The data memory is not instantiated here and lives in the MEM stage. Store data and the address (RAA) are passed forward.

---
 rtl/ex_stage_mc.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with valid/ready handshake, flush and iterative shift-add multiplier.
// Define EX_MULH_EN to add FS=01101 (high half of unsigned A*B) with a 2*DATA_W accumulator.
module ex_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int SH_W     = 5,
    parameter int CTRL_W   = 12,
    parameter int MUL_BITS = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [CTRL_W-1:0] CTRL_in,
    input  logic [4:0]        FS,
    input  logic [SH_W-1:0]   SH,
    input  logic [DATA_W-1:0] BUS_A,
    input  logic [DATA_W-1:0] BUS_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] F,
    output logic              Z,
    output logic              C,
    output logic              N,
    output logic              V,
    output logic              VxorN,
    output logic [DATA_W-1:0] BrA,
    output logic [DATA_W-1:0] RAA,
    output logic [DATA_W-1:0] DATA_out,
    output logic [CTRL_W-1:0] CTRL_out
);
    localparam int ITER  = DATA_W / MUL_BITS;
    localparam int CNT_W = $clog2(ITER + 1);
`ifdef EX_MULH_EN
    localparam int ACC_W = 2 * DATA_W;
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] f_q, f_d, bra_q, bra_d, raa_q, raa_d, dout_q, dout_d, mplier_q, mplier_d;
    logic [ACC_W-1:0]  acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d, vxn_q, vxn_d, mulh_q, mulh_d;
    logic is_add, is_sub, is_mul, is_mulh, accept, ld, rc, rv, alu_c, alu_v;
    logic [DATA_W-1:0] b_eff, alu_f, mul_res, res;
    logic [DATA_W:0]   sum;

    assign is_add = FS == 5'b00001;
    assign is_sub = FS == 5'b00010;
`ifdef EX_MULH_EN
    assign is_mulh = FS == 5'b01101;
`else
    assign is_mulh = 1'b0;
`endif
    assign is_mul = FS == 5'b01100 || is_mulh;
    assign b_eff  = is_sub ? ~BUS_B : BUS_B;
    assign sum    = {1'b0, BUS_A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    assign alu_c  = (is_add || is_sub) && sum[DATA_W];
    assign alu_v  = (is_add || is_sub) && (BUS_A[DATA_W-1] == b_eff[DATA_W-1])
                    && (sum[DATA_W-1] != BUS_A[DATA_W-1]);

    always_comb begin
        alu_f = '0;
        case (FS)
            5'b00000: alu_f = BUS_A;
            5'b00001, 5'b00010: alu_f = sum[DATA_W-1:0];
            5'b00011: alu_f = BUS_A & BUS_B;
            5'b00100: alu_f = BUS_A | BUS_B;
            5'b00101: alu_f = BUS_A ^ BUS_B;
            5'b00110: alu_f = ~BUS_A;
            5'b00111: alu_f = BUS_B;
            5'b01000: alu_f = BUS_A >> SH;
            5'b01001: alu_f = BUS_A << SH;
            5'b01010: alu_f = DATA_W'($signed(BUS_A) >>> SH);
            default:  alu_f = '0;
        endcase
    end

    // One shift-add iteration: add the shifted multiplicand for each of the low MUL_BITS multiplier bits.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < MUL_BITS; i++)
            if (mplier_q[i]) acc_step = acc_step + (mcand_q << i);
    end
    assign mul_res = mulh_q ? acc_step[ACC_W-1 -: DATA_W] : acc_step[DATA_W-1:0];

    assign in_ready = RESET && !flush && (state_q == EMPTY || (state_q == FULL && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        f_d = f_q; bra_d = bra_q; raa_d = raa_q; dout_d = dout_q; ctrl_d = ctrl_q;
        z_d = z_q; c_d = c_q; n_d = n_q; v_d = v_q; vxn_d = vxn_q;
        acc_d = acc_q; mcand_d = mcand_q; mplier_d = mplier_q; cnt_d = cnt_q; mulh_d = mulh_q;
        ld = 1'b0; res = alu_f; rc = alu_c; rv = alu_v;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            bra_d  = PC_in + BUS_B;
            raa_d  = BUS_A;
            dout_d = BUS_B;
            ctrl_d = CTRL_in;
            if (is_mul) begin
                state_d  = BUSY;
                acc_d    = '0;
                mcand_d  = ACC_W'(BUS_A);
                mplier_d = BUS_B;
                cnt_d    = CNT_W'(ITER);
                mulh_d   = is_mulh;
            end else begin
                state_d = FULL;
                ld      = 1'b1;
            end
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end else if (state_q == BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = FULL;
                ld      = 1'b1;
                res     = mul_res;
                rc      = 1'b0;
                rv      = 1'b0;
            end
        end
        if (ld) begin
            f_d   = res;
            z_d   = res == '0;
            n_d   = res[DATA_W-1];
            c_d   = rc;
            v_d   = rv;
            vxn_d = rv ^ res[DATA_W-1];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= EMPTY;
            f_q <= '0; bra_q <= '0; raa_q <= '0; dout_q <= '0; ctrl_q <= '0;
            z_q <= 1'b0; c_q <= 1'b0; n_q <= 1'b0; v_q <= 1'b0; vxn_q <= 1'b0;
            acc_q <= '0; mcand_q <= '0; mplier_q <= '0; cnt_q <= '0; mulh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q <= f_d; bra_q <= bra_d; raa_q <= raa_d; dout_q <= dout_d; ctrl_q <= ctrl_d;
            z_q <= z_d; c_q <= c_d; n_q <= n_d; v_q <= v_d; vxn_q <= vxn_d;
            acc_q <= acc_d; mcand_q <= mcand_d; mplier_q <= mplier_d; cnt_q <= cnt_d; mulh_q <= mulh_d;
        end
    end

    assign out_valid = state_q == FULL;
    assign F         = f_q;
    assign Z         = z_q;
    assign C         = c_q;
    assign N         = n_q;
    assign V         = v_q;
    assign VxorN     = vxn_q;
    assign BrA       = bra_q;
    assign RAA       = raa_q;
    assign DATA_out  = dout_q;
    assign CTRL_out  = ctrl_q;
endmodule
